// File: rtl/debug_slave_cmd_sync.sv
`default_nettype none
// ============================================================================
// Module      : debug_slave_cmd_sync
// Description : System-clock half of the JTAG debug slave. Synchronises the
//               update-IR / update-DR strobes from the TCK domain, latches the
//               instruction, and queues {instruction, data word} commands in a
//               show-ahead FIFO drained through a valid/ready handshake.
//               Overflowing pushes are dropped and flagged in a sticky bit.
// Optional    : `define DEBUG_SLAVE_CH_DECODE_EN adds registered per-channel
//               take_action / take_no_action pulses on every pop. Without it
//               both vectors are tied to zero.
// Ports       : clk, reset         - system clock, sync active-high reset
//               uir_async/ir_in    - update-IR strobe and instruction (TCK)
//               udr_async/sr       - update-DR strobe and data word (TCK)
//               ir_sync/ir_update  - current instruction and load pulse
//               cmd_valid/ready    - command handshake; cmd_ch/data/action
//                                    describe the FIFO head
//               fifo_level         - occupied entries (0..FIFO_DEPTH)
//               overflow/clr_overflow - sticky drop flag and its clear
//               take_action/take_no_action - per-channel decode pulses
// Revision    : 1.0 - initial release
// ============================================================================
module debug_slave_cmd_sync #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,   // 2..4
    parameter int FIFO_DEPTH  = 4    // power of two, >= 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          uir_async,
    input  logic                          udr_async,
    input  logic [IR_W-1:0]               ir_in,
    input  logic [DATA_W-1:0]             sr,
    output logic [IR_W-1:0]               ir_sync,
    output logic                          ir_update,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [IR_W-1:0]               cmd_ch,
    output logic [DATA_W-1:0]             cmd_data,
    output logic                          cmd_action,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [(2**IR_W)-1:0]          take_action,
    output logic [(2**IR_W)-1:0]          take_no_action
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = c_AW + 1;
    localparam int c_EW = IR_W + DATA_W;
    localparam logic [c_LW-1:0] c_LVL_FULL = c_LW'(FIFO_DEPTH);
    localparam logic [c_LW-1:0] c_LVL_ONE  = c_LW'(1);
    localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);

    // ------------------------------------------------------------------
    // Strobe synchronisers and rising-edge detectors
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_uir_sync;
    logic [SYNC_STAGES-1:0] r_udr_sync;
    // r_fill marks when the synchroniser chains hold genuine post-reset
    // samples. A zero at the chain end only arms the detector once the
    // chain has been refilled; otherwise the reset value itself would arm
    // it and a strobe held high across reset would be captured.
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_uir_prev;
    logic                   r_udr_prev;
    logic                   r_uir_armed;
    logic                   r_udr_armed;
    logic                   w_uir_last;
    logic                   w_udr_last;
    logic                   w_uir_rise;
    logic                   w_udr_rise;

    assign w_uir_last = r_uir_sync[SYNC_STAGES-1];
    assign w_udr_last = r_udr_sync[SYNC_STAGES-1];
    assign w_uir_rise = w_uir_last & ~r_uir_prev & r_uir_armed;
    assign w_udr_rise = w_udr_last & ~r_udr_prev & r_udr_armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_uir_sync  <= '0;
            r_udr_sync  <= '0;
            r_fill      <= '0;
            r_uir_prev  <= 1'b0;
            r_udr_prev  <= 1'b0;
            r_uir_armed <= 1'b0;
            r_udr_armed <= 1'b0;
        end else begin
            r_uir_sync  <= {r_uir_sync[SYNC_STAGES-2:0], uir_async};
            r_udr_sync  <= {r_udr_sync[SYNC_STAGES-2:0], udr_async};
            r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_uir_prev  <= w_uir_last;
            r_udr_prev  <= w_udr_last;
            r_uir_armed <= r_uir_armed | (r_fill[SYNC_STAGES-1] & ~w_uir_last);
            r_udr_armed <= r_udr_armed | (r_fill[SYNC_STAGES-1] & ~w_udr_last);
        end
    end

    // ------------------------------------------------------------------
    // Instruction register
    // ------------------------------------------------------------------
    logic [IR_W-1:0] r_ir_sync;
    logic            r_ir_update;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir_sync   <= '0;
            r_ir_update <= 1'b0;
        end else begin
            r_ir_update <= w_uir_rise;
            if (w_uir_rise) begin
                r_ir_sync <= ir_in;
            end
        end
    end

    assign ir_sync   = r_ir_sync;
    assign ir_update = r_ir_update;

    // ------------------------------------------------------------------
    // Command FIFO (show-ahead)
    // ------------------------------------------------------------------
    logic [c_EW-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_LW-1:0] r_level;
    logic [c_EW-1:0] r_last;      // last popped entry, shown while empty
    logic            r_overflow;
    logic            w_valid;
    logic            w_full;
    logic            w_pop;
    logic            w_push_ok;
    logic            w_drop;
    logic [c_EW-1:0] w_head;
    logic [c_EW-1:0] w_out;

    assign w_valid   = (r_level != '0);
    assign w_full    = (r_level == c_LVL_FULL);
    assign w_pop     = w_valid & cmd_ready;
    // When full, a simultaneous pop frees the head slot; the write pointer
    // equals the read pointer then, so the new word lands in that slot and
    // becomes the tail.
    assign w_push_ok = w_udr_rise & (~w_full | w_pop);
    assign w_drop    = w_udr_rise & w_full & ~w_pop;
    assign w_head    = r_mem[r_rd_ptr];
    assign w_out     = w_valid ? w_head : r_last;

    // r_ir_sync is sampled before its own update, so a push coinciding with
    // an IR load carries the previous instruction.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {r_ir_sync, sr};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_last     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                r_last   <= w_head;
            end
            if (w_push_ok && !w_pop) begin
                r_level <= r_level + c_LVL_ONE;
            end else if (!w_push_ok && w_pop) begin
                r_level <= r_level - c_LVL_ONE;
            end
            // Set has priority over clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clr_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign cmd_valid  = w_valid;
    assign cmd_ch     = w_out[c_EW-1:DATA_W];
    assign cmd_data   = w_out[DATA_W-1:0];
    assign cmd_action = w_out[DATA_W-1];
    assign fifo_level = r_level;
    assign overflow   = r_overflow;

    // ------------------------------------------------------------------
    // Optional per-channel action decode
    // ------------------------------------------------------------------
`ifdef DEBUG_SLAVE_CH_DECODE_EN
    logic [(2**IR_W)-1:0] r_take_action;
    logic [(2**IR_W)-1:0] r_take_no_action;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_take_action    <= '0;
            r_take_no_action <= '0;
        end else begin
            r_take_action    <= '0;
            r_take_no_action <= '0;
            if (w_pop) begin
                r_take_action[w_head[c_EW-1:DATA_W]]    <= w_head[DATA_W-1];
                r_take_no_action[w_head[c_EW-1:DATA_W]] <= ~w_head[DATA_W-1];
            end
        end
    end

    assign take_action    = r_take_action;
    assign take_no_action = r_take_no_action;
`else
    assign take_action    = '0;
    assign take_no_action = '0;
`endif

endmodule
`default_nettype wire

// File: doc/debug_slave_cmd_sync.md
Name: debug_slave_cmd_sync

Overview:
System-clock half of the next-generation JTAG debug slave.
- Synchronises the update-IR and update-DR strobes arriving from the TCK-side shift logic.
- Captures the shifted data word together with its instruction into a command FIFO.
- Presents the commands to the CPU debug logic over a valid/ready handshake.
- Generalises the fixed 2-bit-IR, 38-bit, unbuffered decoder to any IR/data width, with buffering, overflow reporting and optional per-channel action decode.

Parameters:
- DATA_W, 38: width of the shifted data word (sr / cmd_data).
- IR_W, 2: instruction width. NUM_CH = 2**IR_W (derived, not overridable).
- SYNC_STAGES, 2: synchroniser flops on each async strobe (legal range 2..4).
- FIFO_DEPTH, 4: command FIFO entries (power of 2, >= 2).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- uir_async  in  1  update-IR level strobe, TCK domain; high >= SYNC_STAGES+1 clk periods
- udr_async  in  1  update-DR level strobe, TCK domain; same width rule
- ir_in  in  IR_W  instruction; stable while uir_async high
- sr  in  DATA_W  shifted data word; stable while udr_async high
- ir_sync  out  IR_W  current instruction in clk domain
- ir_update  out  1  one-cycle pulse when ir_sync is loaded
- cmd_valid  out  1  FIFO head valid
- cmd_ready  in  1  consumer accepts head
- cmd_ch  out  IR_W  head instruction
- cmd_data  out  DATA_W  head data word
- cmd_action  out  1  head data bit DATA_W-1 (action flag)
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries
- overflow  out  1  sticky: a command was dropped
- clr_overflow  in  1  clears overflow
- take_action  out  NUM_CH  see Optional Feature
- take_no_action  out  NUM_CH  see Optional Feature

Behaviour:
Reset values:
- All outputs 0; FIFO empty; synchronisers 0; edge detectors disarmed.

Edge detection:
- Each strobe passes through SYNC_STAGES flops, then a registered copy (prev).
- rise = sync_last & ~prev & armed.
- armed is cleared by reset and set on the first cycle sync_last == 0. A strobe still high across reset release therefore produces no capture.

uir rise:
- Same clock edge: ir_sync <= ir_in; ir_update = 1 for exactly one cycle.

udr rise:
- Pushes {ir_sync, sr} into the FIFO on that edge.
- Latency: first clk edge sampling udr_async high = edge 1; FIFO written at edge SYNC_STAGES+1. On an empty FIFO, cmd_valid is high after that edge (edge 3 for SYNC_STAGES=2).

Simultaneous uir and udr rises:
- The pushed command carries the OLD ir_sync; ir_sync updates on the same edge.

FIFO:
- Show-ahead: cmd_ch, cmd_data and cmd_action reflect the head whenever cmd_valid = 1. They hold value while cmd_valid && !cmd_ready.
- Pop on cmd_valid && cmd_ready. Push and pop on the same edge is legal at any level, including full; fifo_level is unchanged.
- Push with fifo_level == FIFO_DEPTH and no pop: command dropped; overflow <= 1.
- Pointers wrap modulo FIFO_DEPTH. fifo_level is exact 0..FIFO_DEPTH.
- Empty: cmd_valid = 0. Data outputs hold the last-popped value (don't-care to the consumer).
- overflow set and clr_overflow on the same edge: set wins.

Reset mid-operation:
- FIFO flushed, ir_sync = 0, pending strobes discarded. The armed rule applies.

Optional Feature:
Macro DEBUG_SLAVE_CH_DECODE_EN.

Defined:
- On every pop, take_action[cmd_ch] = cmd_action, or take_no_action[cmd_ch] = ~cmd_action.
- The pulse is registered, one cycle wide, one cycle after the pop edge.
- All other bits are 0. Back-to-back pops give back-to-back pulses.

Undefined:
- take_action and take_no_action are tied to 0. No decode logic is synthesised; all other behaviour is identical.

Test Plan:
1. Reset, then ir_in=2'b10 with uir_async high 4 cycles -> ir_update pulses once at edge 3; ir_sync=2'b10.
2. sr=38'h2_0000_0ABC, udr_async high 4 cycles, cmd_ready=0 -> cmd_valid rises after edge 3; cmd_ch=2, cmd_data=38'h2_0000_0ABC, cmd_action=1, fifo_level=1. Raise cmd_ready -> empty next cycle; with the macro defined, take_action=4'b0100 for one cycle.
3. Six udr strobes, cmd_ready=0, FIFO_DEPTH=4 -> fifo_level saturates at 4; overflow=1; the first four words are popped in order. clr_overflow -> overflow=0.
4. FIFO full, cmd_ready=1 while a new udr rise arrives on the same edge -> no overflow; fifo_level stays 4; the new word appears last.
5. uir and udr rising together with ir_sync=1, ir_in=3 -> pushed cmd_ch=1; ir_sync=3 afterwards.
6. udr_async held high through a 3-cycle reset pulse -> no command captured; the next full low-high strobe is captured normally.
